wb_port_arbiter: RTL

//  Shares the single register-file write port between two writeback sources: the ALU result path and the data-memory load-return path.

---
 rtl/wb_port_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the ALU result path and the
// load-return path. Each source owns a one-entry holding slot. Each cycle the grant logic picks
// one full slot. Registered outputs drive the MemtoReg writeback mux and the write strobe.
// Default policy: loads win whenever both slots are full.
// Optional feature macro: WB_AGE_LIMIT_EN adds a saturating ALU age counter. Once the counter
// reaches AGE_MAX, the ALU wins a contested grant.
module wb_port_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned AGE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [ADDR_W-1:0] mem_rd,
  output logic [DATA_W-1:0] ALUOut,
  output logic [DATA_W-1:0] ReadData,
  output logic              MemtoReg,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic              wb_busy
);

  logic              alu_full_q;
  logic [DATA_W-1:0] alu_data_q;
  logic [ADDR_W-1:0] alu_rd_q;
  logic              mem_full_q;
  logic [DATA_W-1:0] mem_data_q;
  logic [ADDR_W-1:0] mem_rd_q;

  logic grant_alu;
  logic grant_mem;
  logic age_hit;
  logic alu_take;
  logic mem_take;

`ifdef WB_AGE_LIMIT_EN
  localparam logic [2:0] AgeMax = 3'(AGE_MAX);

  logic [2:0] age_q;
  logic [2:0] age_d;

  // Age counts cycles the ALU entry waits; it saturates and clears when the ALU is granted.
  always_comb begin
    age_d = age_q;
    if (grant_alu) begin
      age_d = 3'd0;
    end else if (alu_full_q && (age_q != AgeMax)) begin
      age_d = age_q + 3'd1;
    end
  end

  // Age counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q <= 3'd0;
    end else begin
      age_q <= age_d;
    end
  end

  assign age_hit = (age_q == AgeMax);
`else
  // Strict load priority: the ALU never overrides a pending load.
  assign age_hit = 1'b0;
`endif

  // Grant from slot state only; loads win ties unless the ALU has aged out.
  always_comb begin
    grant_mem = mem_full_q & (~alu_full_q | ~age_hit);
    grant_alu = alu_full_q & (~mem_full_q | age_hit);
  end

  // A slot can accept when it is empty or is being drained this cycle; never depends on valid.
  assign alu_ready = ~alu_full_q | grant_alu;
  assign mem_ready = ~mem_full_q | grant_mem;
  assign wb_busy   = alu_full_q | mem_full_q;

  // Beats to r0 are accepted but never occupy a slot.
  assign alu_take = alu_valid & alu_ready & (alu_rd != '0);
  assign mem_take = mem_valid & mem_ready & (mem_rd != '0);

  // Holding slots: load on accept (even while being drained), empty on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_full_q <= 1'b0;
      alu_data_q <= '0;
      alu_rd_q   <= '0;
      mem_full_q <= 1'b0;
      mem_data_q <= '0;
      mem_rd_q   <= '0;
    end else begin
      if (alu_take) begin
        alu_full_q <= 1'b1;
        alu_data_q <= alu_data;
        alu_rd_q   <= alu_rd;
      end else if (grant_alu) begin
        alu_full_q <= 1'b0;
      end
      if (mem_take) begin
        mem_full_q <= 1'b1;
        mem_data_q <= mem_data;
        mem_rd_q   <= mem_rd;
      end else if (grant_mem) begin
        mem_full_q <= 1'b0;
      end
    end
  end

  // Output stage: one-cycle write strobe; the unselected data register keeps its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite <= 1'b0;
      MemtoReg <= 1'b0;
      WriteReg <= '0;
      ALUOut   <= '0;
      ReadData <= '0;
    end else begin
      RegWrite <= grant_alu | grant_mem;
      if (grant_mem) begin
        MemtoReg <= 1'b1;
        WriteReg <= mem_rd_q;
        ReadData <= mem_data_q;
      end else if (grant_alu) begin
        MemtoReg <= 1'b0;
        WriteReg <= alu_rd_q;
        ALUOut   <= alu_data_q;
      end
    end
  end

endmodule
